ifetch_buf: RTL and testbench
=============================

Name: ifetch_buf

Overview:
- Instruction-fetch stage for the miniRV pipeline; produces the inst/pc pair that the decode stage consumes.
- Keeps a fetch PC and issues requests to instruction memory, which accepts requests and returns responses in order with variable latency.
- Holds returned instructions in a small FIFO so decode stalls (ready_i low) do not lose data.
- Handles redirects (taken branch/jump) by flushing the FIFO and discarding responses already in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
DEPTH, 2, FIFO entries and maximum outstanding requests; power of 2, ≥2
CNT_W, 2, counter width; must satisfy CNT_W ≥ log2(DEPTH)+1

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
imem_req_o  out  1  request valid
imem_addr_o  out  32  request word address (byte address, bits [1:0]=0)
imem_ready_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (in order, ≥1 cycle after acceptance)
imem_rdata_i  in  32  response instruction
valid_o  out  1  FIFO head valid
inst_o  out  32  head instruction
pc_o  out  32  head instruction address
ready_i  in  1  decode consumes head this cycle
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (async, any time, including mid-transaction):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
  - valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, inst_o=0, pc_o=0.
- Credit rule:
  - imem_req_o = !redirect_i && (fifo_count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc, combinational from the register.
  - Acceptance = imem_req_o && imem_ready_i. On acceptance: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
  - The FIFO can therefore never overflow.
- Response handling, on imem_rvalid_i:
  - outstanding decrements.
  - If drop>0: drop decrements and the data is discarded.
  - Otherwise push {rdata, pc}. The pc stored is the address of the oldest non-dropped outstanding request, kept in a per-request pc queue or recomputed from a response-side pc counter.
  - A response arriving with outstanding==0 is ignored.
  - Acceptance and response in the same cycle: the outstanding count is unchanged.
- Output:
  - valid_o = FIFO non-empty. inst_o/pc_o driven from the registered head entry; 0 when empty.
  - Pop when valid_o && ready_i.
  - No bypass: a response at cycle t appears on valid_o at t+1 at the earliest.
  - Push and pop in the same cycle are both honoured.
- Redirect (redirect_i=1 at an edge):
  - FIFO cleared; fetch_pc and response pc counter loaded with {redirect_pc_i[31:2],2'b00}.
  - drop = outstanding − (imem_rvalid_i this cycle ? 1 : 0). outstanding itself still tracks the real memory transactions.
  - No request is issued in the redirect cycle.
  - ready_i pop is ignored (FIFO flushed). valid_o=0 the cycle after.
  - First new request is issued the following cycle, provided credit is available (outstanding−drop−… counts toward credit until drained).
  - Back-to-back redirects: the last one wins, and drop accumulates correctly.
- Latency: with memory latency L and ready_i=1, valid_o for the first instruction rises L+1 cycles after request acceptance. Steady-state throughput is 1 instr/cycle when L<DEPTH.
- All state updates on the rising clk_i edge only, apart from async reset.

Test Plan:
- Reset release, memory L=1 always ready, ready_i=1 -> requests to 0x0,0x4,0x8…; valid_o first high 2 cycles after the first request; pc_o sequence 0x0,0x4,0x8 with one instruction per cycle.
- ready_i held 0 for 10 cycles -> exactly DEPTH (2) entries buffered, imem_req_o low. Release ready_i -> 0x0,0x4 emitted then fetch resumes at 0x8, with no loss or duplication.
- L=3, 2 requests outstanding, redirect_i with redirect_pc_i=0x103 -> both stale responses discarded; next request address 0x100; first valid_o shows pc_o=0x100.
- Redirect coinciding with an rvalid and a pop -> that response is dropped, drop=outstanding−1, FIFO empty next cycle, no stale pc emitted.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000 (wrap).
- rst_n_i asserted mid-stream with FIFO full -> all outputs go to reset values immediately (asynchronously). After release, fetch restarts at RESET_PC; a stray rvalid with outstanding=0 is ignored.

Source files
------------

// File: rtl/ifetch_buf.sv
// Instruction-fetch stage: issues in-order imem requests under a credit limit and
// buffers returned instructions with their pc for decode; redirects flush and drop stale data.
module ifetch_buf #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter int          CNT_W    = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic        ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);
   localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_resp_pc;
   logic [CNT_W-1:0] r_outst;
   logic [CNT_W-1:0] r_drop;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [31:0]      r_inst_mem [DEPTH];
   logic [31:0]      r_pc_mem   [DEPTH];

   logic [CNT_W:0] w_credit_sum;
   logic           w_accept;
   logic           w_rsp;
   logic           w_push;
   logic           w_pop;
   logic [31:0]    w_redir_pc;

   // Dropped-but-unreturned requests still hold credit, so the FIFO can never overflow.
   assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outst};
   assign imem_req_o   = rst_n_i && !redirect_i && (w_credit_sum < DEPTH_C);
   assign imem_addr_o  = r_fetch_pc;
   assign w_accept     = imem_req_o && imem_ready_i;
   assign w_rsp        = imem_rvalid_i && (r_outst != '0);
   assign w_push       = w_rsp && (r_drop == '0) && !redirect_i;
   assign w_pop        = valid_o && ready_i && !redirect_i;
   assign w_redir_pc   = redirect_pc_i & 32'hFFFF_FFFC;

   assign valid_o = (r_count != '0);
   assign inst_o  = valid_o ? r_inst_mem[r_rd_ptr] : 32'h0;
   assign pc_o    = valid_o ? r_pc_mem[r_rd_ptr]   : 32'h0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_outst    <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_drop     <= r_outst - CNT_W'(w_rsp);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp && (r_drop != '0)) r_drop <= r_drop - ONE;
            if (w_push) begin
               r_resp_pc <= r_resp_pc + 32'd4;
               r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + ONE;
               2'b01:   r_count <= r_count - ONE;
               default: r_count <= r_count;
            endcase
         end
         case ({w_accept, w_rsp})
            2'b10:   r_outst <= r_outst + ONE;
            2'b01:   r_outst <= r_outst - ONE;
            default: r_outst <= r_outst;
         endcase
      end
   end

   // Payload storage needs no reset: reads are masked by valid_o.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_inst_mem[r_wr_ptr] <= imem_rdata_i;
         r_pc_mem[r_wr_ptr]   <= r_resp_pc;
      end
   end
endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: in-order variable-latency memory, queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ifetch_buf;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        ready_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;

   always #5 clk_i = ~clk_i;

   ifetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .CNT_W(2)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o), .ready_i(ready_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
   );

   typedef struct packed {logic [31:0] pc; logic drop;} req_t;
   typedef struct packed {logic [31:0] inst; logic [31:0] pc;} ent_t;
   typedef struct packed {logic [31:0] addr; int due;} mem_t;

   req_t        m_out[$];
   ent_t        m_fifo[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   mem_t        memq[$];
   logic [31:0] popq[$];
   bit          rv_from_q = 1'b0;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int unsigned k_mready = 100, k_lat_min = 1, k_lat_max = 1, k_dready = 100, k_stray = 0, k_redir = 0;

   logic        s_req, s_acc, s_valid;
   logic [31:0] s_addr, s_inst, s_pc;

   function automatic logic [31:0] f_inst(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   task automatic model_check();
      logic exp_req;
      exp_req = !redirect_i && ((m_fifo.size() + m_out.size()) < DEPTH);
      chk("req", s_req, exp_req);
      chk("addr", s_addr, m_fetch_pc);
      chk("valid", s_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
         chk("inst", s_inst, m_fifo[0].inst);
         chk("pc", s_pc, m_fifo[0].pc);
      end else begin
         chk("inst_empty", s_inst, 32'h0);
         chk("pc_empty", s_pc, 32'h0);
      end
   endtask

   task automatic model_advance();
      bit   do_pop, do_acc;
      req_t r;
      do_acc = !redirect_i && ((m_fifo.size() + m_out.size()) < DEPTH) && imem_ready_i;
      do_pop = (m_fifo.size() > 0) && ready_i && !redirect_i;
      if (do_pop) begin
         popq.push_back(m_fifo[0].pc);
         void'(m_fifo.pop_front());
      end
      if (imem_rvalid_i && m_out.size() > 0) begin
         r = m_out.pop_front();
         if (!r.drop && !redirect_i) m_fifo.push_back({imem_rdata_i, r.pc});
      end
      if (redirect_i) begin
         m_fifo.delete();
         foreach (m_out[i]) m_out[i].drop = 1'b1;
         m_fetch_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (do_acc) begin
         m_out.push_back({m_fetch_pc, 1'b0});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
   endtask

   task automatic drive_inputs();
      imem_ready_i = ($urandom_range(99) < k_mready);
      rv_from_q = 1'b0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = f_inst(memq[0].addr);
         rv_from_q     = 1'b1;
      end else begin
         imem_rvalid_i = (memq.size() == 0) && ($urandom_range(99) < k_stray);
         imem_rdata_i  = $urandom;
      end
      ready_i       = ($urandom_range(99) < k_dready);
      redirect_i    = ($urandom_range(999) < k_redir);
      redirect_pc_i = $urandom;
   endtask

   task automatic cycle();
      @(negedge clk_i);
      s_req = imem_req_o; s_addr = imem_addr_o; s_acc = imem_req_o && imem_ready_i;
      s_valid = valid_o; s_inst = inst_o; s_pc = pc_o;
      model_check();
      model_advance();
      if (imem_rvalid_i && rv_from_q) void'(memq.pop_front());
      if (s_acc) memq.push_back({s_addr, cyc + int'($urandom_range(k_lat_max, k_lat_min))});
      @(posedge clk_i);
      #1;
      cyc++;
      drive_inputs();
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("rst_valid", valid_o, 32'h0);
      chk("rst_req", imem_req_o, 32'h0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      redirect_i = 1'b0; imem_rvalid_i = 1'b0; ready_i = 1'b0; imem_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      m_fifo.delete(); m_out.delete(); memq.delete(); popq.delete();
      m_fetch_pc = RESET_PC;
      cyc = 0;
      rst_n_i = 1'b1;
      drive_inputs();
   endtask

   task automatic run_until_acc(input string name, input logic [31:0] exp_addr);
      int k = 0;
      bit found = 0;
      while (!found && k < 40) begin
         cycle();
         k++;
         if (s_acc) found = 1;
      end
      if (found) chk(name, s_addr, exp_addr);
      else timeout(name);
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      int k = 0;
      bit found = 0;
      while (!found && k < 40) begin
         cycle();
         k++;
         if (s_valid) found = 1;
      end
      if (found) begin
         chk({name, "_pc"}, s_pc, exp_pc);
         chk({name, "_inst"}, s_inst, f_inst(exp_pc));
      end else timeout(name);
   endtask

   task automatic wait_pops(input string name, input int n);
      int k = 0;
      while (popq.size() < n && k < 50) begin
         cycle();
         k++;
      end
      if (popq.size() < n) timeout(name);
      else for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", name, i), popq[i], 32'(4 * i));
   endtask

   initial begin
      int unsigned cfg [4][6] = '{'{100, 1, 1, 100, 0, 20}, '{70, 1, 4, 60, 5, 30},
                                  '{50, 2, 6, 30, 10, 50}, '{90, 1, 3, 90, 3, 10}};
      // Streaming from reset: L=1, always ready.
      do_reset();
      cycle(); chk("t1_first_acc", s_acc, 32'h1); chk("t1_first_addr", s_addr, 32'h0);
      cycle(); chk("t1_valid_c1", s_valid, 32'h0);
      cycle(); chk("t1_valid_c2", s_valid, 32'h1); chk("t1_pc_c2", s_pc, 32'h0);
      chk("t1_inst_c2", s_inst, f_inst(32'h0));
      wait_pops("t1_pop", 3);

      // Decode stall: exactly DEPTH entries buffered, then drained in order.
      k_dready = 0;
      do_reset();
      repeat (10) cycle();
      chk("t2_valid", s_valid, 32'h1); chk("t2_req", s_req, 32'h0); chk("t2_head", s_pc, 32'h0);
      k_dready = 100;
      ready_i = 1'b1;
      wait_pops("t2_pop", 3);

      // Redirect with two stale requests outstanding, L=3.
      k_lat_min = 3; k_lat_max = 3;
      do_reset();
      cycle(); cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
      cycle(); chk("t3_req_redir", s_req, 32'h0);
      run_until_acc("t3_new_addr", 32'h0000_0100);
      wait_valid("t3_first", 32'h0000_0100);

      // Redirect coinciding with a response and a pop.
      k_lat_min = 1; k_lat_max = 1;
      begin
         int k = 0;
         bit hit = 0;
         while (!hit && k < 50) begin
            cycle();
            k++;
            if (imem_rvalid_i && rv_from_q && m_fifo.size() > 0) hit = 1;
         end
         if (!hit) timeout("t4_setup");
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; ready_i = 1'b1;
      cycle(); chk("t4_valid_redir", s_valid, 32'h1); chk("t4_req_redir", s_req, 32'h0);
      cycle(); chk("t4_valid_after", s_valid, 32'h0);
      wait_valid("t4_first", 32'h0000_0200);

      // Fetch pc wrap.
      cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
      run_until_acc("t5_top", 32'hFFFF_FFFC);
      run_until_acc("t5_wrap", 32'h0000_0000);

      // Async reset with FIFO full, then a stray response with nothing outstanding.
      k_dready = 0;
      repeat (8) cycle();
      chk("t6_full_valid", s_valid, 32'h1);
      k_dready = 100; k_stray = 100;
      do_reset();
      chk("t6_stray_driven", imem_rvalid_i, 32'h1);
      cycle(); chk("t6_restart_acc", s_acc, 32'h1); chk("t6_restart_addr", s_addr, RESET_PC);
      k_stray = 0;
      wait_valid("t6_first", RESET_PC);

      // Randomized phases, each starting from an asynchronous reset.
      for (int p = 0; p < 4; p++) begin
         k_mready = cfg[p][0]; k_lat_min = cfg[p][1]; k_lat_max = cfg[p][2];
         k_dready = cfg[p][3]; k_stray = cfg[p][4]; k_redir = cfg[p][5];
         do_reset();
         repeat (2500) cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
